// File: rtl/transfer_pkg.sv
// rtl/transfer_pkg.sv - shared types and defaults for the transfer controller
package transfer_pkg;

   localparam int DES_DIV_DEF = 10;
   localparam int Q_DIV_DEF   = 100;
   localparam int Q_DEPTH_DEF = 8;
   localparam int Q_LEN_W     = 4;
   localparam int DATA_W      = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT_SLOT,
      ST_ENQ,
      ST_ACK
   } xfer_state_t;

endpackage

// File: rtl/transfer_ctrl_if.sv
// rtl/transfer_ctrl_if.sv - deserializer, queue and user signals of the transfer controller
interface transfer_ctrl_if;
   import transfer_pkg::*;

   logic                tick_des;
   logic                tick_q;
   logic                des_data_ready;
   logic [DATA_W-1:0]   des_data;
   logic                des_ack;
   logic                q_enqueue;
   logic [DATA_W-1:0]   q_data;
   logic [Q_LEN_W-1:0]  q_len;
   logic                deq_req;
   logic                q_dequeue;
   logic                overflow;
   logic                underflow;
   logic                busy;

   modport master (
      output tick_des, tick_q, des_ack, q_enqueue, q_data, q_dequeue,
             overflow, underflow, busy,
      input  des_data_ready, des_data, q_len, deq_req
   );

   modport slave (
      input  tick_des, tick_q, des_ack, q_enqueue, q_data, q_dequeue,
             overflow, underflow, busy,
      output des_data_ready, des_data, q_len, deq_req
   );

endinterface

// File: rtl/transfer_ctrl_tick_gen.sv
// rtl/transfer_ctrl_tick_gen.sv - free-running divider producing a one-clk enable pulse
module tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic reset_n,
   output logic o_tick
);

   localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0]  LAST = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Decoded from the count so the pulse sits in the last cycle of each period.
   assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/transfer_ctrl.sv
// rtl/transfer_ctrl.sv - moves deserializer bytes into the queue and schedules user dequeues
module transfer_ctrl
   import transfer_pkg::*;
#(
   parameter int DES_DIV = DES_DIV_DEF,
   parameter int Q_DIV   = Q_DIV_DEF,
   parameter int Q_DEPTH = Q_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   transfer_ctrl_if.master  bus
);

   localparam logic [Q_LEN_W-1:0] Q_FULL = Q_LEN_W'(Q_DEPTH);

   logic              w_tick_des;
   logic              w_tick_q;
   logic              w_slot_free;
   logic              w_enq;
   logic              w_deq;
   logic              w_latch;
   xfer_state_t       r_state;
   xfer_state_t       w_state_nxt;
   logic [DATA_W-1:0] r_q_data;
   logic              r_pend;
   logic              r_overflow;
   logic              r_underflow;

   tick_gen #(.DIV(DES_DIV)) u_tick_des (
      .clk     (clk),
      .reset_n (reset_n),
      .o_tick  (w_tick_des)
   );

   tick_gen #(.DIV(Q_DIV)) u_tick_q (
      .clk     (clk),
      .reset_n (reset_n),
      .o_tick  (w_tick_q)
   );

   // A full queue blocks the enqueue on this tick; a coincident dequeue still goes.
   assign w_slot_free = (bus.q_len < Q_FULL);
   assign w_deq       = w_tick_q && r_pend && (bus.q_len != '0);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_enq       = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.des_data_ready) begin
               w_latch     = 1'b1;
               w_state_nxt = ST_WAIT_SLOT;
            end
         end
         ST_WAIT_SLOT: begin
            if (w_tick_q && w_slot_free) begin
               w_enq       = 1'b1;
               w_state_nxt = ST_ENQ;
            end
         end
         ST_ENQ: begin
            w_state_nxt = ST_ACK;
         end
         ST_ACK: begin
            if (!bus.des_data_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q_data <= '0;
      end else if (w_latch) begin
         r_q_data <= bus.des_data;
      end
   end

   // A request landing on the serving tick is judged against the old flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pend      <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_tick_q && r_pend) begin
            r_pend <= 1'b0;
            if (bus.q_len == '0) begin
               r_underflow <= 1'b1;
            end
         end
         if (bus.deq_req) begin
            if (r_pend) begin
               r_overflow <= 1'b1;
            end else begin
               r_pend <= 1'b1;
            end
         end
      end
   end

   assign bus.tick_des  = w_tick_des;
   assign bus.tick_q    = w_tick_q;
   assign bus.des_ack   = (r_state == ST_ACK);
   assign bus.q_enqueue = w_enq;
   assign bus.q_data    = r_q_data;
   assign bus.q_dequeue = w_deq;
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;
   assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_transfer_ctrl.sv
// tb/tb_transfer_ctrl.sv - scoreboard bench for transfer_ctrl
`timescale 1ns/1ps
module tb_transfer_ctrl;

   localparam int DES_DIV = 10;
   localparam int Q_DIV   = 100;
   localparam int Q_DEPTH = 8;

   typedef struct {
      logic       is_deq;
      logic [7:0] data;
      int         tick;
   } sb_item_t;

   logic     clk;
   logic     reset_n;
   sb_item_t sb_q[$];
   int       n_checks;
   int       n_fail;
   int       tick_cnt;

   transfer_ctrl_if bus ();

   transfer_ctrl #(
      .DES_DIV (DES_DIV),
      .Q_DIV   (Q_DIV),
      .Q_DEPTH (Q_DEPTH)
   ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #500 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic sb_pop(input logic kind);
      sb_item_t it;
      if (sb_q.size() == 0) begin
         check_eq(kind ? "unexpected_dequeue" : "unexpected_enqueue", 1, 0);
      end else begin
         it = sb_q.pop_front();
         check_eq("strobe_kind", {31'b0, kind}, {31'b0, it.is_deq});
         check_eq("strobe_tick_index", tick_cnt, it.tick);
         check_eq("strobe_on_tick_q", {31'b0, bus.tick_q}, 1);
         if (!kind) check_eq("enq_data", {24'b0, bus.q_data}, {24'b0, it.data});
      end
   endtask

   always @(negedge clk) begin
      if (reset_n) begin
         if (bus.tick_q) tick_cnt++;
         if (bus.q_dequeue) sb_pop(1'b1);
         if (bus.q_enqueue) sb_pop(1'b0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_tick();
      for (int i = 0; i < 2 * Q_DIV; i++) begin
         @(negedge clk);
         if (bus.tick_q) begin
            step();
            return;
         end
      end
      check_eq("wait_tick_timeout", 0, 1);
   endtask

   task automatic wait_ack();
      for (int i = 0; i < 3 * Q_DIV; i++) begin
         @(negedge clk);
         if (bus.des_ack) return;
      end
      check_eq("wait_ack_timeout", 0, 1);
   endtask

   task automatic pulse_deq();
      bus.deq_req = 1'b1;
      step();
      bus.deq_req = 1'b0;
   endtask

   task automatic push(input logic is_deq, input logic [7:0] data, input int tick);
      sb_item_t it;
      it.is_deq = is_deq;
      it.data   = data;
      it.tick   = tick;
      sb_q.push_back(it);
   endtask

   initial begin
      int bad_des;
      int bad_q;
      int first_e;
      int lat;
      n_checks = 0;
      n_fail   = 0;
      tick_cnt = 0;
      reset_n  = 1'b0;
      bus.des_data_ready = 1'b0;
      bus.des_data       = 8'h00;
      bus.q_len          = 4'd0;
      bus.deq_req        = 1'b0;
      repeat (3) step();

      check_eq("rst_tick_des",  {31'b0, bus.tick_des},  0);
      check_eq("rst_tick_q",    {31'b0, bus.tick_q},    0);
      check_eq("rst_des_ack",   {31'b0, bus.des_ack},   0);
      check_eq("rst_q_enqueue", {31'b0, bus.q_enqueue}, 0);
      check_eq("rst_q_dequeue", {31'b0, bus.q_dequeue}, 0);
      check_eq("rst_busy",      {31'b0, bus.busy},      0);
      check_eq("rst_overflow",  {31'b0, bus.overflow},  0);
      check_eq("rst_underflow", {31'b0, bus.underflow}, 0);
      check_eq("rst_q_data",    {24'b0, bus.q_data},    0);

      // Tick cadence: after edge e the tick is high when edge e+1 completes a period.
      reset_n = 1'b1;
      bad_des = 0;
      bad_q   = 0;
      first_e = -1;
      for (int e = 1; e <= 250; e++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus.tick_des !== (((e + 1) % DES_DIV) == 0)) bad_des++;
         if (bus.tick_q !== (((e + 1) % Q_DIV) == 0)) bad_q++;
         if (bus.tick_q && first_e < 0) first_e = e;
      end
      check_eq("tick_des_cadence", bad_des, 0);
      check_eq("tick_q_cadence", bad_q, 0);
      check_eq("first_tick_q_edge", first_e + 1, Q_DIV);
      step();

      // Basic transfer into a partly filled queue.
      wait_tick();
      bus.q_len = 4'd3;
      bus.des_data = 8'hA5;
      bus.des_data_ready = 1'b1;
      push(1'b0, 8'hA5, tick_cnt + 1);
      lat = 0;
      for (int i = 0; i < 3 * Q_DIV; i++) begin
         @(negedge clk);
         lat++;
         if (bus.q_enqueue) break;
      end
      check_eq("enq_latency_bound", {31'b0, lat <= Q_DIV + 1}, 1);
      wait_ack();
      check_eq("ack_q_data_held", {24'b0, bus.q_data}, 32'hA5);
      check_eq("ack_busy", {31'b0, bus.busy}, 1);
      step();
      bus.des_data_ready = 1'b0;
      @(negedge clk);
      check_eq("ack_held_after_drop", {31'b0, bus.des_ack}, 1);
      @(negedge clk);
      check_eq("ack_released", {31'b0, bus.des_ack}, 0);
      check_eq("idle_busy", {31'b0, bus.busy}, 0);
      step();

      // Full queue blocks until occupancy drops.
      wait_tick();
      bus.q_len = 4'd8;
      bus.des_data = 8'h3C;
      bus.des_data_ready = 1'b1;
      wait_tick();
      check_eq("full_still_waiting", {31'b0, bus.busy & ~bus.des_ack}, 1);
      repeat (5) step();
      bus.q_len = 4'd7;
      push(1'b0, 8'h3C, tick_cnt + 1);
      wait_ack();
      step();
      bus.des_data_ready = 1'b0;
      repeat (3) step();

      // Dequeue overflow then underflow.
      wait_tick();
      bus.q_len = 4'd2;
      push(1'b1, 8'h00, tick_cnt + 1);
      pulse_deq();
      repeat (3) step();
      check_eq("overflow_before_second", {31'b0, bus.overflow}, 0);
      pulse_deq();
      check_eq("overflow_set", {31'b0, bus.overflow}, 1);
      wait_tick();
      check_eq("underflow_clear", {31'b0, bus.underflow}, 0);
      bus.q_len = 4'd0;
      pulse_deq();
      wait_tick();
      check_eq("underflow_set", {31'b0, bus.underflow}, 1);
      check_eq("overflow_sticky", {31'b0, bus.overflow}, 1);

      // Coincident enqueue/dequeue on a full queue: dequeue first, enqueue one tick later.
      wait_tick();
      bus.q_len = 4'd8;
      bus.des_data = 8'h5A;
      bus.des_data_ready = 1'b1;
      push(1'b1, 8'h00, tick_cnt + 1);
      pulse_deq();
      wait_tick();
      bus.q_len = 4'd7;
      push(1'b0, 8'h5A, tick_cnt + 1);
      wait_ack();
      step();
      bus.des_data_ready = 1'b0;
      repeat (3) step();

      // Coincident with room: both strobes on the same tick.
      wait_tick();
      bus.q_len = 4'd4;
      bus.des_data = 8'hC3;
      bus.des_data_ready = 1'b1;
      push(1'b1, 8'h00, tick_cnt + 1);
      push(1'b0, 8'hC3, tick_cnt + 1);
      pulse_deq();
      wait_ack();
      step();
      bus.des_data_ready = 1'b0;
      repeat (3) step();

      // Reset while acknowledging.
      wait_tick();
      bus.q_len = 4'd1;
      bus.des_data = 8'h77;
      bus.des_data_ready = 1'b1;
      push(1'b0, 8'h77, tick_cnt + 1);
      wait_ack();
      check_eq("in_ack_before_reset", {31'b0, bus.des_ack}, 1);
      #100;
      reset_n = 1'b0;
      #1;
      check_eq("abort_des_ack",   {31'b0, bus.des_ack},   0);
      check_eq("abort_busy",      {31'b0, bus.busy},      0);
      check_eq("abort_q_data",    {24'b0, bus.q_data},    0);
      check_eq("abort_overflow",  {31'b0, bus.overflow},  0);
      check_eq("abort_underflow", {31'b0, bus.underflow}, 0);
      check_eq("abort_strobes",   {30'b0, bus.q_enqueue, bus.q_dequeue}, 0);
      check_eq("abort_ticks",     {30'b0, bus.tick_des, bus.tick_q}, 0);
      bus.des_data_ready = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      repeat (250) step();
      check_eq("post_reset_idle", {31'b0, bus.busy}, 0);
      check_eq("scoreboard_drained", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
